// File: rtl/ram_test_pkg.sv
// Shared definitions for the dual-port RAM test design.
// Holds the read-checker FSM states, the default geometry shared with the
// write-side generator, and the expected-pattern function used by both sides.
package ram_test_pkg;

  // Default RAM geometry, shared by the read checker and the write generator
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 32;

  // Read checker sequencing: wait, sweep, let the RAM pipeline empty, report
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  // Expected word at an address; callers truncate the result to their data width
  function automatic logic [31:0] pat_word(input logic [31:0] addr, input int offset);
    return addr + 32'(offset);
  endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Valid/address shift register that tracks reads in flight through the RAM.
// The tap lines up each issued address with the data the RAM returns
// RD_LATENCY cycles later. Reset clears every stage asynchronously so an
// aborted pass leaves no stale compares behind.
module rd_lat_pipe
  import ram_test_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              tap_valid,
  output logic [ADDR_W-1:0] tap_addr
);

  logic [RD_LATENCY-1:0] vld;
  logic [ADDR_W-1:0]     adr [RD_LATENCY];

  // Shift each issued read one stage further per cycle; stage 0 takes the new read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        adr[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      adr[0] <= in_addr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        adr[i] <= adr[i-1];
      end
    end
  end

  assign tap_valid = vld[RD_LATENCY-1];
  assign tap_addr  = adr[RD_LATENCY-1];

endmodule

// File: rtl/ram_rd_checker.sv
// Read-side checker for the dual-port RAM test design.
// A start pulse sweeps every read address once, compares each returned word
// with the expected pattern and reports busy, a done pulse, pass and an
// error count. Defining RAM_RD_CHECKER_FIRST_ERR_EN adds first_err_addr and
// first_err_data, which capture the first mismatch of a pass.
module ram_rd_checker
  import ram_test_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int RD_LATENCY = 2,
  parameter int PAT_OFFSET = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt
`ifdef RAM_RD_CHECKER_FIRST_ERR_EN
  ,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
`endif
);

  rd_state_e         state;
  logic [2:0]        drain_cnt;
  logic              accept;
  logic              tap_valid;
  logic [ADDR_W-1:0] tap_addr;
  logic [DATA_W-1:0] want_data;
  logic              mism;
  logic [ADDR_W:0]   err_next;

  rd_lat_pipe #(
    .ADDR_W    (ADDR_W),
    .RD_LATENCY(RD_LATENCY)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (ram_rd_en),
    .in_addr  (ram_rd_addr),
    .tap_valid(tap_valid),
    .tap_addr (tap_addr)
  );

  // A start only counts while idle; anything else is dropped, not queued
  assign accept    = (state == IDLE) && start;

  // Compare the word arriving now against the address that requested it
  assign want_data = DATA_W'(pat_word(32'(tap_addr), PAT_OFFSET));
  assign mism      = tap_valid && (ram_rd_data != want_data);
  assign err_next  = err_cnt + {{ADDR_W{1'b0}}, mism};

  // Sequencer: issue DEPTH back-to-back reads, wait out the RAM latency, then pulse done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      drain_cnt   <= '0;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= READ;
            ram_rd_en   <= 1'b1;
            ram_rd_addr <= '0;
            busy        <= 1'b1;
            pass        <= 1'b0;
          end
        end
        READ: begin
          if (ram_rd_addr == ADDR_W'(DEPTH - 1)) begin
            state     <= DRAIN;
            ram_rd_en <= 1'b0;
            drain_cnt <= '0;
          end else begin
            ram_rd_addr <= ram_rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == 3'(RD_LATENCY - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Error counter: cleared when a pass is accepted, bumped on every mismatching word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (accept) begin
      err_cnt <= '0;
    end else begin
      err_cnt <= err_next;
    end
  end

`ifdef RAM_RD_CHECKER_FIRST_ERR_EN
  // Keep the address and data of the first mismatch until the next accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (accept) begin
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (mism && (err_cnt == '0)) begin
      first_err_addr <= tap_addr;
      first_err_data <= ram_rd_data;
    end
  end
`endif

endmodule

// File: tb/tb_ram_rd_checker.sv
// Testbench for ram_rd_checker.
// Four checkers run side by side: instance 0 (latency 2, offset 0) reads a
// writable RAM model and takes the main scenarios; instances 1..3 (latency 1,
// latency 4, offset 250) read fixed pattern RAMs and run one clean pass.
// Expected pass results are queued when a start is driven and compared when
// the checker pulses done.
module tb_ram_rd_checker;

  localparam int DEPTH = 32;
  localparam int NDUT  = 4;

  typedef struct {
    int s0;
    int err;
    int pas;
    int fe_addr;
    int fe_data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic start_x;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   s0_last;

  logic       rd_en_v [NDUT];
  logic [4:0] addr_v  [NDUT];
  logic [7:0] data_v  [NDUT];
  logic       busy_v  [NDUT];
  logic       done_v  [NDUT];
  logic       pass_v  [NDUT];
  logic [5:0] err_v   [NDUT];
`ifdef RAM_RD_CHECKER_FIRST_ERR_EN
  logic [4:0] fe_addr_v [NDUT];
  logic [7:0] fe_data_v [NDUT];
`endif

  logic [7:0] mem0  [DEPTH];
  logic [7:0] rpipe [NDUT][4];

  exp_t sb_q   [NDUT][$];
  int   act_s0 [NDUT];

  function automatic int lat_of(input int i);
    case (i)
      1:       return 1;
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic int off_of(input int i);
    return (i == 3) ? 250 : 0;
  endfunction

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ram_rd_checker #(
      .ADDR_W    (5),
      .DATA_W    (8),
      .DEPTH     (DEPTH),
      .RD_LATENCY(lat_of(g)),
      .PAT_OFFSET(off_of(g))
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      ((g == 0) ? start : start_x),
      .ram_rd_en  (rd_en_v[g]),
      .ram_rd_addr(addr_v[g]),
      .ram_rd_data(data_v[g]),
      .busy       (busy_v[g]),
      .done       (done_v[g]),
      .pass       (pass_v[g]),
      .err_cnt    (err_v[g])
`ifdef RAM_RD_CHECKER_FIRST_ERR_EN
      ,
      .first_err_addr(fe_addr_v[g]),
      .first_err_data(fe_data_v[g])
`endif
    );
  end

  // Behavioral RAM read ports: word captured on the address edge, delayed to the read latency
  always @(posedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (i == 0) rpipe[i][0] <= mem0[addr_v[i]];
      else        rpipe[i][0] <= 8'(int'(addr_v[i]) + off_of(i));
      for (int s = 1; s < 4; s++) rpipe[i][s] <= rpipe[i][s-1];
    end
  end

  always_comb begin
    for (int i = 0; i < NDUT; i++) data_v[i] = rpipe[i][lat_of(i)-1];
  end

  task automatic checkOutput(input string tag, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, want, cyc);
    end
  endtask

  // Reference model: derive the outcome of a pass from the RAM contents
  task automatic pushExp(input int i, input int s);
    exp_t e;
    int   ram;
    int   want;
    e.s0 = s; e.err = 0; e.fe_addr = 0; e.fe_data = 0;
    for (int k = 0; k < DEPTH; k++) begin
      want = (k + off_of(i)) % 256;
      ram  = (i == 0) ? int'(mem0[k]) : (k + off_of(i)) % 256;
      if (ram != want) begin
        if (e.err == 0) begin
          e.fe_addr = k;
          e.fe_data = ram;
        end
        e.err++;
      end
    end
    e.pas = (e.err == 0) ? 1 : 0;
    sb_q[i].push_back(e);
    act_s0[i] = s;
  endtask

  // Drive one start pulse that the checker(s) will accept and queue the expected result
  task automatic applyStimulus(input bit extra);
    @(negedge clk);
    if (extra) start_x = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    start_x = 1'b0;
    s0_last = cyc;
    if (extra) begin
      for (int i = 1; i < NDUT; i++) pushExp(i, s0_last);
    end else begin
      pushExp(0, s0_last);
    end
  endtask

  // Pulse start on instance 0 during cycle c of the current pass, expecting no effect
  task automatic pulseAt(input int c);
    @(negedge clk);
    while ((cyc - s0_last + 1) < c) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NDUT; i++) n += sb_q[i].size();
    return n;
  endfunction

  task automatic waitIdle(input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (pending() != 0) begin
      checkOutput("done_timeout", pending(), 0);
      for (int i = 0; i < NDUT; i++) begin
        sb_q[i].delete();
        act_s0[i] = -1;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rd_en"}, rd_en_v[0], 0);
    checkOutput({tag, "_addr"},  addr_v[0],  0);
    checkOutput({tag, "_busy"},  busy_v[0],  0);
    checkOutput({tag, "_done"},  done_v[0],  0);
    checkOutput({tag, "_pass"},  pass_v[0],  0);
    checkOutput({tag, "_err"},   err_v[0],   0);
`ifdef RAM_RD_CHECKER_FIRST_ERR_EN
    checkOutput({tag, "_fe_addr"}, fe_addr_v[0], 0);
    checkOutput({tag, "_fe_data"}, fe_data_v[0], 0);
`endif
  endtask

  // Monitor: per-cycle sweep checks while a pass is active, scoreboard pop on done
  always @(negedge clk) begin : mon
    int   rel;
    int   lat;
    exp_t e;
    for (int i = 0; i < NDUT; i++) begin
      if (rst !== 1'b1 && act_s0[i] >= 0) begin
        rel = cyc - act_s0[i] + 1;
        lat = lat_of(i);
        if (rel == 1) begin
          checkOutput($sformatf("err_clear%0d", i), err_v[i], 0);
          checkOutput($sformatf("pass_clear%0d", i), pass_v[i], 0);
        end
        if (rel >= 1 && rel <= DEPTH) begin
          checkOutput($sformatf("rd_en%0d", i), rd_en_v[i], 1);
          checkOutput($sformatf("rd_addr%0d", i), addr_v[i], rel - 1);
          checkOutput($sformatf("busy%0d", i), busy_v[i], 1);
        end else if (rel > DEPTH && rel <= DEPTH + lat) begin
          checkOutput($sformatf("drain_rd_en%0d", i), rd_en_v[i], 0);
          checkOutput($sformatf("drain_addr%0d", i), addr_v[i], DEPTH - 1);
          checkOutput($sformatf("drain_busy%0d", i), busy_v[i], 1);
        end
      end
      if (rst !== 1'b1 && done_v[i] === 1'b1) begin
        if (sb_q[i].size() == 0) begin
          checkOutput($sformatf("unexpected_done%0d", i), 1, 0);
        end else begin
          e = sb_q[i].pop_front();
          checkOutput($sformatf("done_cycle%0d", i), cyc - e.s0 + 1, DEPTH + lat_of(i) + 1);
          checkOutput($sformatf("err_cnt%0d", i), err_v[i], e.err);
          checkOutput($sformatf("pass%0d", i), pass_v[i], e.pas);
          checkOutput($sformatf("done_busy%0d", i), busy_v[i], 0);
          checkOutput($sformatf("done_rd_en%0d", i), rd_en_v[i], 0);
`ifdef RAM_RD_CHECKER_FIRST_ERR_EN
          checkOutput($sformatf("first_err_addr%0d", i), fe_addr_v[i], e.fe_addr);
          checkOutput($sformatf("first_err_data%0d", i), fe_data_v[i], e.fe_data);
`endif
          act_s0[i] = -1;
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    start = 1'b0;
    start_x = 1'b0;
    for (int i = 0; i < NDUT; i++) act_s0[i] = -1;
    for (int k = 0; k < DEPTH; k++) mem0[k] = 8'(k);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] clean pass");
    applyStimulus(1'b0);
    waitIdle(100);

    $display("[TB] corrupted words at 3 and 31");
    mem0[3]  = 8'hFF;
    mem0[31] = 8'h00;
    applyStimulus(1'b0);
    waitIdle(100);

    $display("[TB] start while busy");
    applyStimulus(1'b0);
    pulseAt(5);
    pulseAt(34);
    @(posedge clk);
    applyStimulus(1'b0);
    checkOutput("restart_cycle", s0_last - 1 - (cyc - 1), 0);
    waitIdle(100);

    $display("[TB] reset mid-pass");
    for (int k = 0; k < DEPTH; k++) mem0[k] = 8'(k);
    mem0[2] = 8'h55;
    applyStimulus(1'b0);
    @(negedge clk);
    while ((cyc - s0_last + 1) < 10) @(negedge clk);
    checkOutput("pre_reset_err", err_v[0], 1);
    #2 rst = 1'b1;
    #1;
    checkResetValues("abort");
    sb_q[0].delete();
    act_s0[0] = -1;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    mem0[2] = 8'h02;
    applyStimulus(1'b0);
    waitIdle(100);

    $display("[TB] latency 1/4 and offset 250 instances");
    applyStimulus(1'b1);
    waitIdle(100);

    checkOutput("scoreboard_empty", pending(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
